audio_stream_sequencer: RTL and testbench
=========================================

Name: audio_stream_sequencer

Overview:
- AXI4-lite configured sequencer for the stereo audio output path.
- Software pushes packed stereo samples into an internal FIFO. A programmable sample-rate pacer pops one sample per period and drives registered `channel_a_o` / `channel_b_o` to the DAC/PWM stage.
- Provides level/status reporting, sticky underrun/overflow flags and a low-watermark interrupt, so the CPU refills in bursts instead of writing every sample.

Parameters:
- FIFO_AW, 6, log2 of FIFO depth (64 entries × 32 bits); level field is FIFO_AW+1 bits.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- cfg_awvalid_i  input  1  write address valid
- cfg_awaddr_i  input  32  write address (bits [4:2] decoded)
- cfg_wvalid_i  input  1  write data valid
- cfg_wdata_i  input  32  write data
- cfg_wstrb_i  input  4  write strobes (ignored; full-word writes)
- cfg_bready_i  input  1  write response ready
- cfg_arvalid_i  input  1  read address valid
- cfg_araddr_i  input  32  read address (bits [4:2] decoded)
- cfg_rready_i  input  1  read data ready
- cfg_awready_o  output  1  write address ready
- cfg_wready_o  output  1  write data ready
- cfg_bvalid_o  output  1  write response valid
- cfg_bresp_o  output  2  always 2'b00
- cfg_arready_o  output  1  read address ready
- cfg_rvalid_o  output  1  read data valid
- cfg_rdata_o  output  32  read data
- cfg_rresp_o  output  2  always 2'b00
- channel_a_o  output  16  signed sample, channel A (registered)
- channel_b_o  output  16  signed sample, channel B (registered)
- sample_strobe_o  output  1  one-cycle pulse, high in the first cycle new channel values are presented
- irq_o  output  1  low-watermark interrupt, level sensitive

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Async reset clears every register and all outputs to 0: FIFO empty, DIV=0, THRESH=0, CTRL=0, sticky flags 0.
- Register map (word offsets)
  - 0x00 CTRL: [0] enable, [1] flush (write-1, self-clearing, reads 0).
  - 0x04 DIV: [15:0]; tick every DIV+1 cycles.
  - 0x08 FIFO (write-only): [15:0] channel A, [31:16] channel B; reads return 0.
  - 0x0C STATUS (read-only except W1C): [FIFO_AW:0] level, [16] full, [17] empty, [18] underrun sticky, [19] overflow sticky. Writing 1 to bit 18 or 19 clears that flag.
  - 0x10 THRESH: [FIFO_AW:0] low watermark.
  - Unmapped offsets read 0 and ignore writes.
- Write channel
  - `awready` = `wready` = ~bvalid & awvalid & wvalid; AW and W are accepted in the same cycle only.
  - `bvalid` sets the cycle after acceptance and holds until `bready`. One outstanding write.
- Read channel
  - `arready` = ~rvalid.
  - `rdata` is registered; `rvalid` rises 1 cycle after acceptance and holds, data stable, until `rready`.
  - If a read and a write are accepted in the same cycle, the read returns the pre-write value.
- Pacer
  - 16-bit counter runs only when enable=1; held at 0 when enable=0.
  - tick = enable & (count >= DIV); on tick the counter returns to 0.
  - If DIV is lowered below the current count, the next cycle ticks.
- Pop
  - On tick with FIFO non-empty, the head is popped into `channel_a_o`/`channel_b_o` at that clock edge and `sample_strobe_o` = 1 for the following cycle.
  - On tick with FIFO empty: channels hold their last value, `sample_strobe_o` still pulses, and the underrun flag sets.
- Push
  - A FIFO write when full (level == 2^FIFO_AW) is dropped and sets the overflow flag.
  - Push and pop in the same cycle: level unchanged.
  - A push to an empty FIFO coincident with a tick still counts as underrun; the data is stored.
  - Full and empty are derived from the level.
- Flush
  - Sets level to 0 and read/write pointers equal in one cycle.
  - Channels hold their values; a coincident push is discarded.
- irq_o = enable & (level <= THRESH), registered, so it has 1-cycle lag.
- Disable mid-stream: FIFO contents, channel outputs and flags are retained; resuming re-enables popping after DIV+1 cycles.
- Reset mid-transaction drops any pending bvalid/rvalid immediately.

Test Plan:
- Reset → all outputs 0, STATUS reads 0x0002_0000 (empty=1, level 0), irq_o=0.
- DIV=3, push {B=0x0002,A=0x0001} and {0xFFFE,0x7FFF}, enable → `sample_strobe_o` pulses every 4 cycles. Channels show 0x0001/0x0002, then 0x7FFF/0xFFFE (−2). The third strobe sets underrun (STATUS bit18=1) and outputs are held.
- Push 65 samples with enable=0, FIFO_AW=6 → level=64, full=1, overflow bit19=1. Writing 0x0008_0000 to STATUS clears bit19 only.
- THRESH=2, level 4, DIV=0, enable → irq_o rises when level reaches 2, 1 cycle lagged. Continuous pops each cycle drain to 0 with 4 strobes.
- Push coincident with pop at level 5 → level stays 5. Flush with a coincident push → level 0, channels unchanged.
- Back-to-back AXI read of STATUS with rready low for 3 cycles → rdata stable, arready=0 until handshake. Write with awvalid but no wvalid → not accepted.

Source files
------------

// File: rtl/audio_stream_sequencer_if.sv
// AXI4-lite configuration port of the stereo audio sequencer.
// The CPU side is the master; the sequencer is the slave.
interface audio_stream_sequencer_if;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/audio_stream_sequencer.sv
// Stereo audio sequencer: software fills a sample FIFO over AXI4-lite and a
// programmable pacer pops one packed {B,A} sample per period onto the outputs.
module audio_stream_sequencer #(
  parameter int FIFO_AW = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  audio_stream_sequencer_if.slave   cfg,
  output logic [15:0]               channel_a_o,
  output logic [15:0]               channel_b_o,
  output logic                      sample_strobe_o,
  output logic                      irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_DIV    = 3'd1,
    REG_FIFO   = 3'd2,
    REG_STATUS = 3'd3,
    REG_THRESH = 3'd4
  } reg_sel_e;

  // Configuration and status state
  logic               enable_q;
  logic [15:0]        div_q;
  logic [FIFO_AW:0]   thresh_q;
  logic               underrun_q;
  logic               overflow_q;

  // Bus state
  logic               bvalid_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;

  // Pacer and FIFO state
  logic [15:0]        count_q;
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic [31:0]        mem [DEPTH];

  logic [2:0]         wr_sel;
  logic [2:0]         rd_sel;
  logic               wr_acc;
  logic               rd_acc;
  logic               wr_ctrl;
  logic               wr_div;
  logic               wr_fifo;
  logic               wr_status;
  logic               wr_thresh;
  logic               flush;
  logic               full;
  logic               empty;
  logic               tick;
  logic               push;
  logic               pop;
  logic               underrun_set;
  logic               overflow_set;
  logic [31:0]        rd_word;
  logic               unused_cfg;

  assign wr_sel = cfg.awaddr[4:2];
  assign rd_sel = cfg.araddr[4:2];

  // AW and W must arrive together; only one write may be outstanding.
  assign wr_acc      = ~bvalid_q & cfg.awvalid & cfg.wvalid;
  assign rd_acc      = ~rvalid_q & cfg.arvalid;
  assign cfg.awready = wr_acc;
  assign cfg.wready  = wr_acc;
  assign cfg.arready = ~rvalid_q;
  assign cfg.bvalid  = bvalid_q;
  assign cfg.bresp   = 2'b00;
  assign cfg.rvalid  = rvalid_q;
  assign cfg.rdata   = rdata_q;
  assign cfg.rresp   = 2'b00;

  assign wr_ctrl   = wr_acc & (wr_sel == REG_CTRL);
  assign wr_div    = wr_acc & (wr_sel == REG_DIV);
  assign wr_fifo   = wr_acc & (wr_sel == REG_FIFO);
  assign wr_status = wr_acc & (wr_sel == REG_STATUS);
  assign wr_thresh = wr_acc & (wr_sel == REG_THRESH);
  assign flush     = wr_ctrl & cfg.wdata[1];

  // Level can never exceed DEPTH, so its top bit alone marks a full FIFO.
  assign full  = level_q[FIFO_AW];
  assign empty = (level_q == '0);

  assign tick         = enable_q & (count_q >= div_q);
  assign pop          = tick & ~empty & ~flush;
  assign push         = wr_fifo & ~full & ~flush;
  assign underrun_set = tick & empty;
  assign overflow_set = wr_fifo & full;

  // Address bits outside [4:2] and the byte strobes carry no meaning here.
  assign unused_cfg = ^{cfg.wstrb, cfg.awaddr[31:5], cfg.awaddr[1:0],
                        cfg.araddr[31:5], cfg.araddr[1:0]};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    rd_word = '0;
    case (rd_sel)
      REG_CTRL:   rd_word[0] = enable_q;
      REG_DIV:    rd_word[15:0] = div_q;
      REG_STATUS: begin
        rd_word[FIFO_AW:0] = level_q;
        rd_word[16]        = full;
        rd_word[17]        = empty;
        rd_word[18]        = underrun_q;
        rd_word[19]        = overflow_q;
      end
      REG_THRESH: rd_word[FIFO_AW:0] = thresh_q;
      default:    rd_word = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_acc) begin
        bvalid_q <= 1'b1;
      end else if (cfg.bready) begin
        bvalid_q <= 1'b0;
      end
      // The read word is captured from pre-edge state, so a coincident write is not yet visible.
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (cfg.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q   <= 1'b0;
      div_q      <= '0;
      thresh_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= cfg.wdata[0];
      end
      if (wr_div) begin
        div_q <= cfg.wdata[15:0];
      end
      if (wr_thresh) begin
        thresh_q <= cfg.wdata[FIFO_AW:0];
      end
      // A new event in the same cycle as its W1C clear wins, so no event is lost.
      underrun_q <= underrun_set | (underrun_q & ~(wr_status & cfg.wdata[18]));
      overflow_q <= overflow_set | (overflow_q & ~(wr_status & cfg.wdata[19]));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (!enable_q || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: the sample array has no reset; the pointers and level define which entries are valid, so clearing storage buys nothing.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= cfg.wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      channel_a_o     <= '0;
      channel_b_o     <= '0;
      sample_strobe_o <= 1'b0;
      irq_o           <= 1'b0;
    end else begin
      if (pop) begin
        channel_a_o <= mem[rd_ptr_q][15:0];
        channel_b_o <= mem[rd_ptr_q][31:16];
      end
      // Underrun ticks still strobe so the DAC stage keeps its sample cadence.
      sample_strobe_o <= tick;
      irq_o           <= enable_q & (level_q <= thresh_q);
    end
  end

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer: register access, pacing, FIFO
// boundaries, watermark interrupt, flush and bus handshake corner cases.
module tb_audio_stream_sequencer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_DIV    = 32'h04;
  localparam logic [31:0] A_FIFO   = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_THRESH = 32'h10;
  localparam logic [31:0] A_UNMAP  = 32'h14;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] channel_a;
  logic [15:0] channel_b;
  logic        sample_strobe;
  logic        irq;
  int          total = 0;
  int          bad   = 0;

  always #5 clk_i = ~clk_i;

  audio_stream_sequencer_if cfg ();

  audio_stream_sequencer #(.FIFO_AW(6)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg             (cfg),
    .channel_a_o     (channel_a),
    .channel_b_o     (channel_b),
    .sample_strobe_o (sample_strobe),
    .irq_o           (irq)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int waited = 0;
    cfg.awaddr  = addr;
    cfg.wdata   = data;
    cfg.wstrb   = 4'hF;
    cfg.awvalid = 1'b1;
    cfg.wvalid  = 1'b1;
    #1;
    while (cfg.awready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (cfg.awready !== 1'b1) begin
      bad++;
      $display("FAIL write_timeout addr=%h awready=%b want 1", addr, cfg.awready);
    end
    total++;
    @(posedge clk_i);
    #1;
    cfg.awvalid = 1'b0;
    cfg.wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int waited = 0;
    cfg.araddr  = addr;
    cfg.arvalid = 1'b1;
    #1;
    while (cfg.arready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    @(posedge clk_i);
    #1;
    cfg.arvalid = 1'b0;
    waited = 0;
    while (cfg.rvalid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (cfg.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL read_timeout addr=%h rvalid=%b want 1", addr, cfg.rvalid);
    end
    total++;
    data = cfg.rdata;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_i = 1'b1;
    repeat (3) step();
    if ({channel_a, channel_b} !== 32'h0) begin
      bad++; $display("FAIL reset_channels got=%h want=%h", {channel_a, channel_b}, 32'h0);
    end
    total++;
    if ({sample_strobe, irq, cfg.bvalid, cfg.rvalid} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", {sample_strobe, irq, cfg.bvalid, cfg.rvalid}, 4'b0000);
    end
    total++;
    rst_i = 1'b0;
    step();
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0002_0000) begin
      bad++; $display("FAIL reset_status got=%h want=%h", rd, 32'h0002_0000);
    end
    total++;
    axi_read(A_THRESH, rd);
    if (rd !== 32'h0) begin
      bad++; $display("FAIL reset_thresh got=%h want=%h", rd, 32'h0);
    end
    total++;
  endtask

  task automatic test_pacer();
    logic [31:0] rd;
    axi_write(A_DIV, 32'd3);
    axi_write(A_FIFO, 32'h0002_0001);
    axi_write(A_FIFO, 32'hFFFE_7FFF);
    axi_write(A_CTRL, 32'h1);
    for (int n = 1; n <= 13; n++) begin
      step();
      if (sample_strobe !== ((n % 4) == 0)) begin
        bad++; $display("FAIL pacer_strobe cycle=%0d got=%b want=%b", n, sample_strobe, (n % 4) == 0);
      end
      total++;
      if (n == 4) begin
        if ({channel_b, channel_a} !== 32'h0002_0001) begin
          bad++; $display("FAIL pacer_first got=%h want=%h", {channel_b, channel_a}, 32'h0002_0001);
        end
        total++;
      end
      if (n == 8 || n == 12) begin
        if ({channel_b, channel_a} !== 32'hFFFE_7FFF) begin
          bad++; $display("FAIL pacer_second cycle=%0d got=%h want=%h", n, {channel_b, channel_a}, 32'hFFFE_7FFF);
        end
        total++;
      end
    end
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0006_0000) begin
      bad++; $display("FAIL pacer_underrun got=%h want=%h", rd, 32'h0006_0000);
    end
    total++;
    axi_write(A_CTRL, 32'h0);
    axi_write(A_STATUS, 32'h0004_0000);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0002_0000) begin
      bad++; $display("FAIL pacer_w1c got=%h want=%h", rd, 32'h0002_0000);
    end
    total++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    for (int i = 0; i < 65; i++) axi_write(A_FIFO, 32'(i));
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0009_0040) begin
      bad++; $display("FAIL overflow_status got=%h want=%h", rd, 32'h0009_0040);
    end
    total++;
    axi_write(A_STATUS, 32'h0008_0000);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0001_0040) begin
      bad++; $display("FAIL overflow_clear got=%h want=%h", rd, 32'h0001_0040);
    end
    total++;
    axi_write(A_CTRL, 32'h2);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0002_0000) begin
      bad++; $display("FAIL overflow_flush got=%h want=%h", rd, 32'h0002_0000);
    end
    total++;
  endtask

  task automatic test_irq_drain();
    logic [31:0] rd;
    for (int k = 0; k < 4; k++) axi_write(A_FIFO, 32'h1000_0100 + 32'h0001_0001 * 32'(k));
    axi_write(A_THRESH, 32'd2);
    axi_write(A_DIV, 32'd0);
    axi_write(A_CTRL, 32'h1);
    for (int n = 1; n <= 4; n++) begin
      step();
      if ({sample_strobe, irq} !== {1'b1, n >= 3}) begin
        bad++; $display("FAIL drain_strobe_irq cycle=%0d got=%b want=%b", n, {sample_strobe, irq}, {1'b1, n >= 3});
      end
      total++;
      if ({channel_b, channel_a} !== (32'h1000_0100 + 32'h0001_0001 * 32'(n - 1))) begin
        bad++; $display("FAIL drain_sample cycle=%0d got=%h want=%h", n, {channel_b, channel_a},
                        32'h1000_0100 + 32'h0001_0001 * 32'(n - 1));
      end
      total++;
    end
    axi_write(A_CTRL, 32'h0);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0006_0000) begin
      bad++; $display("FAIL drain_status got=%h want=%h", rd, 32'h0006_0000);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL drain_irq_off got=%b want=0", irq);
    end
    total++;
    axi_write(A_STATUS, 32'h0004_0000);
  endtask

  task automatic test_push_pop_flush();
    logic [31:0] rd;
    axi_write(A_DIV, 32'd3);
    for (int k = 0; k < 5; k++) axi_write(A_FIFO, {16'hBEEF, 16'(k)});
    axi_write(A_CTRL, 32'h1);
    repeat (3) step();
    axi_write(A_FIFO, {16'hBEEF, 16'h0005});
    if ({sample_strobe, channel_b, channel_a} !== {1'b1, 32'hBEEF_0000}) begin
      bad++; $display("FAIL coincident_pop got=%h want=%h", {sample_strobe, channel_b, channel_a}, {1'b1, 32'hBEEF_0000});
    end
    total++;
    axi_write(A_CTRL, 32'h0);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0000_0005) begin
      bad++; $display("FAIL coincident_level got=%h want=%h", rd, 32'h0000_0005);
    end
    total++;
    axi_write(A_CTRL, 32'h2);
    axi_read(A_STATUS, rd);
    if (rd !== 32'h0002_0000) begin
      bad++; $display("FAIL flush_status got=%h want=%h", rd, 32'h0002_0000);
    end
    total++;
    if ({channel_b, channel_a} !== 32'hBEEF_0000) begin
      bad++; $display("FAIL flush_hold got=%h want=%h", {channel_b, channel_a}, 32'hBEEF_0000);
    end
    total++;
  endtask

  task automatic test_axi_handshake();
    logic [31:0] rd;
    step();
    step();
    cfg.rready  = 1'b0;
    cfg.araddr  = A_STATUS;
    cfg.arvalid = 1'b1;
    #1;
    step();
    for (int i = 0; i < 3; i++) begin
      if ({cfg.arready, cfg.rvalid, cfg.rdata} !== {2'b01, 32'h0002_0000}) begin
        bad++; $display("FAIL read_hold cycle=%0d got=%h want=%h", i, {cfg.arready, cfg.rvalid, cfg.rdata},
                        {2'b01, 32'h0002_0000});
      end
      total++;
      step();
    end
    cfg.rready = 1'b1;
    step();
    if (cfg.arready !== 1'b1) begin
      bad++; $display("FAIL read_release got=%b want=1", cfg.arready);
    end
    total++;
    cfg.arvalid = 1'b0;
    step();
    step();

    cfg.awaddr  = A_DIV;
    cfg.wdata   = 32'h55;
    cfg.awvalid = 1'b1;
    cfg.wvalid  = 1'b0;
    #1;
    if ({cfg.awready, cfg.wready} !== 2'b00) begin
      bad++; $display("FAIL aw_only_ready got=%b want=%b", {cfg.awready, cfg.wready}, 2'b00);
    end
    total++;
    repeat (3) step();
    if (cfg.bvalid !== 1'b0) begin
      bad++; $display("FAIL aw_only_bvalid got=%b want=0", cfg.bvalid);
    end
    total++;
    cfg.awvalid = 1'b0;
    axi_read(A_DIV, rd);
    if (rd !== 32'd3) begin
      bad++; $display("FAIL aw_only_div got=%h want=%h", rd, 32'd3);
    end
    total++;

    cfg.awaddr  = A_DIV;
    cfg.wdata   = 32'd7;
    cfg.awvalid = 1'b1;
    cfg.wvalid  = 1'b1;
    cfg.araddr  = A_DIV;
    cfg.arvalid = 1'b1;
    #1;
    if ({cfg.awready, cfg.arready} !== 2'b11) begin
      bad++; $display("FAIL same_cycle_ready got=%b want=%b", {cfg.awready, cfg.arready}, 2'b11);
    end
    total++;
    step();
    cfg.awvalid = 1'b0;
    cfg.wvalid  = 1'b0;
    cfg.arvalid = 1'b0;
    if ({cfg.rvalid, cfg.rdata} !== {1'b1, 32'd3}) begin
      bad++; $display("FAIL same_cycle_old got=%h want=%h", {cfg.rvalid, cfg.rdata}, {1'b1, 32'd3});
    end
    total++;
    step();
    axi_read(A_DIV, rd);
    if (rd !== 32'd7) begin
      bad++; $display("FAIL same_cycle_new got=%h want=%h", rd, 32'd7);
    end
    total++;
    axi_read(A_FIFO, rd);
    if (rd !== 32'h0) begin
      bad++; $display("FAIL fifo_read_zero got=%h want=%h", rd, 32'h0);
    end
    total++;
    axi_read(A_UNMAP, rd);
    if (rd !== 32'h0) begin
      bad++; $display("FAIL unmapped_read got=%h want=%h", rd, 32'h0);
    end
    total++;
    axi_read(A_CTRL, rd);
    if (rd !== 32'h0) begin
      bad++; $display("FAIL ctrl_flush_reads_zero got=%h want=%h", rd, 32'h0);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    cfg.bready = 1'b0;
    axi_write(A_DIV, 32'd9);
    step();
    if (cfg.bvalid !== 1'b1) begin
      bad++; $display("FAIL bvalid_hold got=%b want=1", cfg.bvalid);
    end
    total++;
    rst_i = 1'b1;
    #1;
    if (cfg.bvalid !== 1'b0) begin
      bad++; $display("FAIL reset_drops_bvalid got=%b want=0", cfg.bvalid);
    end
    total++;
    step();
    rst_i      = 1'b0;
    cfg.bready = 1'b1;
    step();
    axi_read(A_DIV, rd);
    if (rd !== 32'h0) begin
      bad++; $display("FAIL reset_mid_div got=%h want=%h", rd, 32'h0);
    end
    total++;
  endtask

  initial begin
    rst_i       = 1'b1;
    cfg.awvalid = 1'b0;
    cfg.awaddr  = '0;
    cfg.wvalid  = 1'b0;
    cfg.wdata   = '0;
    cfg.wstrb   = 4'hF;
    cfg.bready  = 1'b1;
    cfg.arvalid = 1'b0;
    cfg.araddr  = '0;
    cfg.rready  = 1'b1;
    test_reset();
    test_pacer();
    test_overflow();
    test_irq_drain();
    test_push_pop_flush();
    test_axi_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
